mdriver_regfile: RTL and testbench



---
 rtl/mdriver_regs_pkg.sv | 45 ++++
 rtl/mdriver_sync_fifo.sv | 61 ++++++
 rtl/mdriver_regfile.sv | 176 +++++++++++++++++
 tb/tb_mdriver_regfile.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mdriver_regs_pkg.sv
// Shared register-map constants, FIFO_STAT field positions and the address decoder
// used by the mdriver register-file responder.
package mdriver_regs_pkg;

  localparam int unsigned ADDR_ID        = 0;
  localparam int unsigned ADDR_CTRL      = 1;
  localparam int unsigned ADDR_STATUS    = 2;
  localparam int unsigned ADDR_FIFO_DATA = 3;
  localparam int unsigned ADDR_FIFO_STAT = 4;
  localparam int unsigned ADDR_RX_POP    = 5;
  localparam int unsigned ADDR_SCRATCH   = 6;

  localparam int FS_TX_FULL    = 0;
  localparam int FS_RX_EMPTY   = 1;
  localparam int FS_TX_OVF     = 2;
  localparam int FS_RX_UNF     = 3;
  localparam int FS_TX_CNT_LSB = 8;
  localparam int FS_RX_CNT_LSB = 16;
  localparam int FS_CNT_W      = 8;

  typedef enum logic [2:0] {
    SEL_ID,
    SEL_CTRL,
    SEL_STATUS,
    SEL_FIFO_DATA,
    SEL_FIFO_STAT,
    SEL_RX_POP,
    SEL_SCRATCH,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input int unsigned addr);
    case (addr)
      ADDR_ID:        return SEL_ID;
      ADDR_CTRL:      return SEL_CTRL;
      ADDR_STATUS:    return SEL_STATUS;
      ADDR_FIFO_DATA: return SEL_FIFO_DATA;
      ADDR_FIFO_STAT: return SEL_FIFO_STAT;
      ADDR_RX_POP:    return SEL_RX_POP;
      ADDR_SCRATCH:   return SEL_SCRATCH;
      default:        return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mdriver_sync_fifo.sv
// Single-clock FIFO with a combinational head. Push is refused when full even if a
// pop happens in the same cycle; pop is ignored when empty.
module mdriver_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DW-1:0]              head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mdriver_regfile.sv
// Register-file responder for the mdriver slave end: decode, CTRL/STATUS/SCRATCH,
// sticky FIFO flags, TX/RX FIFO bridges and the registered read-data path.
module mdriver_regfile
  import mdriver_regs_pkg::*;
#(
  parameter bit          OPT_READ_SIDEEFFECTS = 1'b1,
  parameter int          C_AXI_DATA_WIDTH     = 32,
  parameter int          C_AXI_ADDR_WIDTH     = 8,
  parameter int          FIFO_DEPTH           = 8,
  parameter logic [31:0] ID_VALUE             = 32'h5345_5255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [C_AXI_ADDR_WIDTH-1:0] si_address,
  input  logic [C_AXI_DATA_WIDTH-1:0] si_data,
  input  logic                        we,
  output logic [C_AXI_DATA_WIDTH-1:0] so_data,
  output logic [C_AXI_DATA_WIDTH-1:0] ctrl_o,
  input  logic [C_AXI_DATA_WIDTH-1:0] status_set_i,
  output logic [C_AXI_DATA_WIDTH-1:0] tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  input  logic [C_AXI_DATA_WIDTH-1:0] rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready
);

  localparam int DW = C_AXI_DATA_WIDTH;
  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e      w_sel;
  logic          w_rd_start;
  logic          w_tx_push_req;
  logic          w_rx_pop_req;
  logic          w_fs_wr;
  logic [DW-1:0] w_status_clr;
  logic [DW-1:0] w_status_next;
  logic [DW-1:0] w_fifo_stat;
  logic [DW-1:0] w_rd_data;

  logic          w_tx_full;
  logic          w_tx_empty;
  logic [CW-1:0] w_tx_count;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [CW-1:0] w_rx_count;
  logic [DW-1:0] w_rx_head;

  logic [DW-1:0] r_ctrl;
  logic [DW-1:0] r_status;
  logic [DW-1:0] r_scratch;
  logic [DW-1:0] r_so_data;
  logic          r_tx_ovf;
  logic          r_rx_unf;
  logic          r_first;
  logic          r_prev_we;
  logic [AW-1:0] r_prev_addr;

  assign w_sel = decode_addr(32'(si_address));

  // A read access begins when the bus switches to reading or moves to a new address.
  assign w_rd_start = !we && (r_prev_we || (si_address != r_prev_addr) || r_first);

  assign w_tx_push_req = we && (w_sel == SEL_FIFO_DATA);
  assign w_fs_wr       = we && (w_sel == SEL_FIFO_STAT);
  assign w_rx_pop_req  = (we && (w_sel == SEL_RX_POP)) ||
                         (OPT_READ_SIDEEFFECTS && w_rd_start && (w_sel == SEL_FIFO_DATA));

  always_comb begin
    w_status_clr = '0;
    if (we && (w_sel == SEL_STATUS)) begin
      w_status_clr = si_data;
    end else if (OPT_READ_SIDEEFFECTS && w_rd_start && (w_sel == SEL_STATUS)) begin
      w_status_clr = '1;
    end
  end

  // Set pulses are ORed after the clear so a same-cycle set always survives.
  assign w_status_next = (r_status & ~w_status_clr) | status_set_i;

  always_comb begin
    w_fifo_stat                                = '0;
    w_fifo_stat[FS_TX_FULL]                    = w_tx_full;
    w_fifo_stat[FS_RX_EMPTY]                   = w_rx_empty;
    w_fifo_stat[FS_TX_OVF]                     = r_tx_ovf;
    w_fifo_stat[FS_RX_UNF]                     = r_rx_unf;
    w_fifo_stat[FS_TX_CNT_LSB +: FS_CNT_W]     = FS_CNT_W'(w_tx_count);
    w_fifo_stat[FS_RX_CNT_LSB +: FS_CNT_W]     = FS_CNT_W'(w_rx_count);
  end

  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      SEL_ID:        w_rd_data = DW'(ID_VALUE);
      SEL_CTRL:      w_rd_data = r_ctrl;
      SEL_STATUS:    w_rd_data = r_status;
      SEL_FIFO_DATA: w_rd_data = w_rx_empty ? '0 : w_rx_head;
      SEL_FIFO_STAT: w_rd_data = w_fifo_stat;
      SEL_SCRATCH:   w_rd_data = r_scratch;
      default:       w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl      <= '0;
      r_status    <= '0;
      r_scratch   <= '0;
      r_so_data   <= '0;
      r_tx_ovf    <= 1'b0;
      r_rx_unf    <= 1'b0;
      r_first     <= 1'b1;
      r_prev_we   <= 1'b0;
      r_prev_addr <= '0;
    end else begin
      r_first     <= 1'b0;
      r_prev_we   <= we;
      r_prev_addr <= si_address;
      r_status    <= w_status_next;
      r_so_data   <= w_rd_data;
      if (we && (w_sel == SEL_CTRL)) begin
        r_ctrl <= si_data;
      end
      if (we && (w_sel == SEL_SCRATCH)) begin
        r_scratch <= si_data;
      end
      if (w_tx_push_req && w_tx_full) begin
        r_tx_ovf <= 1'b1;
      end else if (w_fs_wr && si_data[FS_TX_OVF]) begin
        r_tx_ovf <= 1'b0;
      end
      if (w_rx_pop_req && w_rx_empty) begin
        r_rx_unf <= 1'b1;
      end else if (w_fs_wr && si_data[FS_RX_UNF]) begin
        r_rx_unf <= 1'b0;
      end
    end
  end

  mdriver_sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_tx_push_req),
    .push_data (si_data),
    .pop       (tx_ready),
    .full      (w_tx_full),
    .empty     (w_tx_empty),
    .count     (w_tx_count),
    .head      (tx_data)
  );

  mdriver_sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (w_rx_pop_req),
    .full      (w_rx_full),
    .empty     (w_rx_empty),
    .count     (w_rx_count),
    .head      (w_rx_head)
  );

  assign so_data  = r_so_data;
  assign ctrl_o   = r_ctrl;
  assign tx_valid = !w_tx_empty;
  assign rx_ready = !w_rx_full;

endmodule

// File: tb/tb_mdriver_regfile.sv
// Directed bench for mdriver_regfile: one instance with read side effects, one without,
// both driven by the same bus stimulus and checked against hand-computed values.
module tb_mdriver_regfile;

  localparam logic [31:0] ID = 32'h5345_5255;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  si_address = '0;
  logic [31:0] si_data = '0;
  logic        we = 1'b0;
  logic [31:0] status_set_i = '0;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;

  logic [31:0] so_1, ctrl_1, txd_1;
  logic        txv_1, rxr_1;
  logic [31:0] so_0, ctrl_0, txd_0;
  logic        txv_0, rxr_0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mdriver_regfile #(.OPT_READ_SIDEEFFECTS(1'b1)) dut (
    .clk(clk), .reset(reset), .si_address(si_address), .si_data(si_data), .we(we),
    .so_data(so_1), .ctrl_o(ctrl_1), .status_set_i(status_set_i),
    .tx_data(txd_1), .tx_valid(txv_1), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rxr_1)
  );

  mdriver_regfile #(.OPT_READ_SIDEEFFECTS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .si_address(si_address), .si_data(si_data), .we(we),
    .so_data(so_0), .ctrl_o(ctrl_0), .status_set_i(status_set_i),
    .tx_data(txd_0), .tx_valid(txv_0), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rxr_0)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; si_address = a; si_data = d;
    cycle();
    $display("txn wr addr=%02h data=%08h", a, d);
    we = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a);
    we = 1'b0; si_address = a;
    cycle();
    $display("txn rd addr=%02h so=%08h so_nse=%08h", a, so_1, so_0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    n_cmp++; if (so_1 !== 32'h0) begin n_bad++; $display("FAIL rst_so got %08h want 00000000", so_1); end
    n_cmp++; if (ctrl_1 !== 32'h0) begin n_bad++; $display("FAIL rst_ctrl got %08h want 00000000", ctrl_1); end
    n_cmp++; if (txv_1 !== 1'b0) begin n_bad++; $display("FAIL rst_tx_valid got %b want 0", txv_1); end
    n_cmp++; if (rxr_1 !== 1'b1) begin n_bad++; $display("FAIL rst_rx_ready got %b want 1", rxr_1); end
    do_read(8'h00);
    n_cmp++; if (so_1 !== ID) begin n_bad++; $display("FAIL id_read got %08h want %08h", so_1, ID); end
    do_read(8'h04);
    n_cmp++; if (so_1 !== 32'h2) begin n_bad++; $display("FAIL rst_fifo_stat got %08h want 00000002", so_1); end
  endtask

  task automatic test_ctrl_scratch();
    do_write(8'h01, 32'hA5A5_0001);
    n_cmp++; if (ctrl_1 !== 32'hA5A5_0001) begin n_bad++; $display("FAIL ctrl_o got %08h want a5a50001", ctrl_1); end
    n_cmp++; if (so_1 !== 32'h0) begin n_bad++; $display("FAIL wr_cycle_so got %08h want 00000000", so_1); end
    do_read(8'h01);
    n_cmp++; if (so_1 !== 32'hA5A5_0001) begin n_bad++; $display("FAIL ctrl_read got %08h want a5a50001", so_1); end
    do_read(8'h07);
    n_cmp++; if (so_1 !== 32'h0) begin n_bad++; $display("FAIL unmapped_read got %08h want 00000000", so_1); end
    do_write(8'h06, 32'h1234_5678);
    do_read(8'h06);
    n_cmp++; if (so_1 !== 32'h1234_5678) begin n_bad++; $display("FAIL scratch_read got %08h want 12345678", so_1); end
    do_write(8'h00, 32'hFFFF_FFFF);
    do_read(8'h00);
    n_cmp++; if (so_1 !== ID) begin n_bad++; $display("FAIL id_readonly got %08h want %08h", so_1, ID); end
  endtask

  task automatic test_status();
    status_set_i = 32'h5;
    do_read(8'h00);
    status_set_i = 32'h0;
    do_read(8'h02);
    n_cmp++; if (so_1 !== 32'h5) begin n_bad++; $display("FAIL status_first got %08h want 00000005", so_1); end
    n_cmp++; if (so_0 !== 32'h5) begin n_bad++; $display("FAIL status_nse_first got %08h want 00000005", so_0); end
    for (int i = 0; i < 2; i++) begin
      do_read(8'h02);
      n_cmp++; if (so_1 !== 32'h0) begin n_bad++; $display("FAIL status_cleared[%0d] got %08h want 00000000", i, so_1); end
      n_cmp++; if (so_0 !== 32'h5) begin n_bad++; $display("FAIL status_nse_held[%0d] got %08h want 00000005", i, so_0); end
    end
    do_write(8'h02, 32'h1);
    do_read(8'h02);
    n_cmp++; if (so_0 !== 32'h4) begin n_bad++; $display("FAIL status_w1c got %08h want 00000004", so_0); end
    do_read(8'h00);
    status_set_i = 32'h2;
    do_read(8'h02);
    status_set_i = 32'h0;
    n_cmp++; if (so_1 !== 32'h0) begin n_bad++; $display("FAIL status_preclear got %08h want 00000000", so_1); end
    do_read(8'h02);
    n_cmp++; if (so_1 !== 32'h2) begin n_bad++; $display("FAIL status_set_wins got %08h want 00000002", so_1); end
    n_cmp++; if (so_0 !== 32'h6) begin n_bad++; $display("FAIL status_nse_or got %08h want 00000006", so_0); end
  endtask

  task automatic test_tx_fifo();
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      do_write(8'h03, 32'h100 + 32'(i));
    end
    n_cmp++; if (txv_1 !== 1'b1) begin n_bad++; $display("FAIL tx_valid got %b want 1", txv_1); end
    do_read(8'h04);
    n_cmp++; if (so_1 !== 32'h0000_0807) begin n_bad++; $display("FAIL tx_full_stat got %08h want 00000807", so_1); end
    do_write(8'h04, 32'h4);
    do_read(8'h04);
    n_cmp++; if (so_1 !== 32'h0000_0803) begin n_bad++; $display("FAIL tx_ovf_w1c got %08h want 00000803", so_1); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (txv_1 !== 1'b1 || txd_1 !== 32'h100 + 32'(i)) begin
        n_bad++; $display("FAIL tx_drain[%0d] got v=%b d=%08h want v=1 d=%08h", i, txv_1, txd_1, 32'h100 + 32'(i));
      end
      cycle();
      $display("txn tx_pop idx=%0d", i);
    end
    tx_ready = 1'b0;
    n_cmp++; if (txv_1 !== 1'b0) begin n_bad++; $display("FAIL tx_empty_after got %b want 0", txv_1); end
  endtask

  task automatic test_rx_fifo();
    si_address = 8'h00;
    rx_valid = 1'b1;
    rx_data = 32'h11;
    cycle();
    rx_data = 32'h22;
    cycle();
    rx_valid = 1'b0;
    $display("txn rx_push 00000011 00000022");
    do_read(8'h03);
    n_cmp++; if (so_1 !== 32'h11) begin n_bad++; $display("FAIL rx_first got %08h want 00000011", so_1); end
    n_cmp++; if (so_0 !== 32'h11) begin n_bad++; $display("FAIL rx_nse_first got %08h want 00000011", so_0); end
    do_write(8'h05, 32'h0);
    do_read(8'h03);
    n_cmp++; if (so_1 !== 32'h0) begin n_bad++; $display("FAIL rx_empty_read got %08h want 00000000", so_1); end
    n_cmp++; if (so_0 !== 32'h22) begin n_bad++; $display("FAIL rx_nse_second got %08h want 00000022", so_0); end
    do_read(8'h04);
    n_cmp++; if (so_1 !== 32'h0000_000A) begin n_bad++; $display("FAIL rx_unf_stat got %08h want 0000000a", so_1); end
    n_cmp++; if (so_0 !== 32'h0001_0000) begin n_bad++; $display("FAIL rx_nse_stat got %08h want 00010000", so_0); end
    do_write(8'h05, 32'h0);
    do_write(8'h05, 32'h0);
    do_read(8'h04);
    n_cmp++; if (so_0 !== 32'h0000_000A) begin n_bad++; $display("FAIL rx_pop_unf got %08h want 0000000a", so_0); end
    do_write(8'h04, 32'h8);
    do_read(8'h04);
    n_cmp++; if (so_1 !== 32'h2) begin n_bad++; $display("FAIL rx_unf_w1c got %08h want 00000002", so_1); end
    n_cmp++; if (so_0 !== 32'h2) begin n_bad++; $display("FAIL rx_nse_unf_w1c got %08h want 00000002", so_0); end
  endtask

  task automatic test_reset_midop();
    si_address = 8'h00;
    rx_valid = 1'b1;
    rx_data = 32'h33;
    cycle();
    rx_data = 32'h44;
    cycle();
    rx_valid = 1'b0;
    do_write(8'h03, 32'h55);
    do_write(8'h03, 32'h66);
    do_read(8'h04);
    n_cmp++; if (so_1 !== 32'h0002_0200) begin n_bad++; $display("FAIL pre_reset_stat got %08h want 00020200", so_1); end
    reset = 1'b1; we = 1'b1; si_address = 8'h01; si_data = 32'hDEAD_BEEF;
    cycle();
    $display("txn reset with pending wr addr=01");
    reset = 1'b0; we = 1'b0;
    n_cmp++; if (ctrl_1 !== 32'h0) begin n_bad++; $display("FAIL midrst_ctrl got %08h want 00000000", ctrl_1); end
    n_cmp++; if (so_1 !== 32'h0) begin n_bad++; $display("FAIL midrst_so got %08h want 00000000", so_1); end
    n_cmp++; if (txv_1 !== 1'b0) begin n_bad++; $display("FAIL midrst_tx_valid got %b want 0", txv_1); end
    n_cmp++; if (rxr_1 !== 1'b1) begin n_bad++; $display("FAIL midrst_rx_ready got %b want 1", rxr_1); end
    do_read(8'h04);
    n_cmp++; if (so_1 !== 32'h2) begin n_bad++; $display("FAIL midrst_stat got %08h want 00000002", so_1); end
    do_read(8'h01);
    n_cmp++; if (so_1 !== 32'h0) begin n_bad++; $display("FAIL midrst_ctrl_read got %08h want 00000000", so_1); end
  endtask

  initial begin
    test_reset();
    test_ctrl_scratch();
    test_status();
    test_tx_fifo();
    test_rx_fifo();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
